dmem_cache: RTL and testbench

DMEM_CACHE -- requirements
Module: dmem_cache

---
 rtl/dmem_cache.sv | 135 +++++++++++++
 tb/tb_dmem_cache.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/dmem_cache.sv
// Direct-mapped, write-through / no-write-allocate data cache with one-word lines.
// Optional read hit/miss counters are compiled in with DMEM_CACHE_STATS_EN.
module dmem_cache #(
  parameter int unsigned LINES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_rd_en,
  input  logic        cpu_wr_en,
  input  logic [31:0] cpu_w_data,
  output logic [31:0] cpu_r_data,
  output logic        stall,
  output logic [31:0] mem_addr,
  output logic        mem_wr_en,
  output logic [31:0] mem_w_data,
  input  logic [31:0] mem_r_data
);

  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = 30 - IDX_W;

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t state, state_next;

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES];
  logic [31:0]      miss_addr;

  logic [IDX_W-1:0] idx, miss_idx;
  logic [TAG_W-1:0] tag, miss_tag;
  logic             hit;
  logic             rd_miss, fill_we, store_we;
  logic             unused_addr_bits;

  assign idx      = cpu_addr[IDX_W+1:2];
  assign tag      = cpu_addr[31:IDX_W+2];
  assign miss_idx = miss_addr[IDX_W+1:2];
  assign miss_tag = miss_addr[31:IDX_W+2];
  assign hit      = valid[idx] && (tag_mem[idx] == tag);

  assign unused_addr_bits = ^{cpu_addr[1:0], miss_addr[1:0]};

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    mem_wr_en  = 1'b0;
    mem_addr   = cpu_addr;
    mem_w_data = cpu_w_data;
    cpu_r_data = '0;
    rd_miss    = 1'b0;
    fill_we    = 1'b0;
    store_we   = 1'b0;
    case (state)
      IDLE: begin
        // A simultaneous read and write is handled purely as a store.
        if (cpu_wr_en) begin
          mem_wr_en = 1'b1;
          store_we  = hit;
        end else if (cpu_rd_en) begin
          if (hit) begin
            cpu_r_data = data_mem[idx];
          end else begin
            stall      = 1'b1;
            rd_miss    = 1'b1;
            state_next = FILL;
          end
        end
      end
      FILL: begin
        stall      = 1'b1;
        mem_addr   = miss_addr;
        fill_we    = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        stall      = 1'b1;
        mem_addr   = miss_addr;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (reset) begin
      stall      = 1'b0;
      mem_wr_en  = 1'b0;
      cpu_r_data = '0;
      rd_miss    = 1'b0;
      fill_we    = 1'b0;
      store_we   = 1'b0;
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      valid     <= '0;
      miss_addr <= '0;
    end else begin
      state <= state_next;
      if (rd_miss) miss_addr <= cpu_addr;
      if (fill_we) valid[miss_idx] <= 1'b1;
    end
  end

  // Array contents need no reset; the valid bits alone gate their use.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_mem[miss_idx] <= mem_r_data;
      tag_mem[miss_idx]  <= miss_tag;
    end else if (store_we) begin
      data_mem[idx] <= cpu_w_data;
    end
  end

`ifdef DMEM_CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
  logic        rd_hit;

  assign rd_hit = !reset && (state == IDLE) && cpu_rd_en && !cpu_wr_en && hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (rd_hit && (hit_count != '1))   hit_count  <= hit_count + 32'd1;
      if (rd_miss && (miss_count != '1)) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_cache.sv
// Directed bench for dmem_cache: table of single-cycle IDLE vectors plus
// hand sequences for miss fills, reset during a fill and no-write-allocate.
module tb_dmem_cache;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_addr;
  logic        cpu_rd_en;
  logic        cpu_wr_en;
  logic [31:0] cpu_w_data;
  logic [31:0] cpu_r_data;
  logic        stall;
  logic [31:0] mem_addr;
  logic        mem_wr_en;
  logic [31:0] mem_w_data;
  logic [31:0] mem_r_data;

  logic [31:0] dmem [256];

  int n_cmp = 0;
  int n_err = 0;

  dmem_cache #(.LINES(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_addr   (cpu_addr),
    .cpu_rd_en  (cpu_rd_en),
    .cpu_wr_en  (cpu_wr_en),
    .cpu_w_data (cpu_w_data),
    .cpu_r_data (cpu_r_data),
    .stall      (stall),
    .mem_addr   (mem_addr),
    .mem_wr_en  (mem_wr_en),
    .mem_w_data (mem_w_data),
    .mem_r_data (mem_r_data)
  );

  always #5 clk = ~clk;

  // rw_ram model: registered read, data valid the cycle after the address.
  always @(posedge clk) begin
    if (mem_wr_en) dmem[mem_addr[9:2]] <= mem_w_data;
    mem_r_data <= dmem[mem_addr[9:2]];
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_stall;
    logic        exp_mwe;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issues a read expected to miss; returns stall cycles seen after the request cycle.
  task automatic do_read_miss(input logic [31:0] addr, input logic [31:0] exp, output int stalls);
    cpu_addr  = addr;
    cpu_rd_en = 1'b1;
    cpu_wr_en = 1'b0;
    @(negedge clk);
    check("miss_req_stall", {31'd0, stall}, 32'd1);
    check("miss_req_mem_addr", mem_addr, addr);
    check("miss_req_mem_wr_en", {31'd0, mem_wr_en}, 32'd0);
    stalls = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (!stall) break;
      stalls++;
    end
    check("miss_penalty", stalls, 32'd2);
    check("miss_rdata", cpu_r_data, exp);
    @(posedge clk);
    #1;
    cpu_rd_en = 1'b0;
  endtask

  initial begin
    int s, total;

    for (int i = 0; i < 256; i++) dmem[i] = 32'h1000 + i;
    dmem[21] = 32'd7;

    //          rd    wr    addr   wdata  stall mwe  rdata
    vecs[0] = '{1'b0, 1'b0, 32'd84, 32'hAA, 1'b0, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'd84, 32'h0,  1'b0, 1'b0, 32'd7};
    vecs[2] = '{1'b0, 1'b1, 32'd84, 32'h55, 1'b0, 1'b1, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 32'd84, 32'h0,  1'b0, 1'b0, 32'h55};
    vecs[4] = '{1'b1, 1'b1, 32'd84, 32'h66, 1'b0, 1'b1, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 32'd84, 32'h0,  1'b0, 1'b0, 32'h66};

    reset = 1'b1; cpu_addr = 32'd84; cpu_rd_en = 1'b0; cpu_wr_en = 1'b0; cpu_w_data = 32'h0;
    @(posedge clk);
    #1;
    cpu_rd_en = 1'b1; cpu_wr_en = 1'b1; cpu_w_data = 32'h1234;
    @(negedge clk);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_mem_wr_en", {31'd0, mem_wr_en}, 32'd0);
    check("rst_rdata", cpu_r_data, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0; cpu_rd_en = 1'b0; cpu_wr_en = 1'b0;

    do_read_miss(32'd84, 32'd7, s);

    for (int i = 0; i < 6; i++) begin
      cpu_rd_en  = vecs[i].rd;
      cpu_wr_en  = vecs[i].wr;
      cpu_addr   = vecs[i].addr;
      cpu_w_data = vecs[i].wdata;
      @(negedge clk);
      check($sformatf("vec%0d_stall", i), {31'd0, stall}, {31'd0, vecs[i].exp_stall});
      check($sformatf("vec%0d_mem_wr_en", i), {31'd0, mem_wr_en}, {31'd0, vecs[i].exp_mwe});
      check($sformatf("vec%0d_mem_addr", i), mem_addr, vecs[i].addr);
      check($sformatf("vec%0d_mem_w_data", i), mem_w_data, vecs[i].wdata);
      check($sformatf("vec%0d_rdata", i), cpu_r_data, vecs[i].exp_rdata);
      @(posedge clk);
      #1;
    end
    cpu_rd_en = 1'b0; cpu_wr_en = 1'b0;
    check("dmem21_written_through", dmem[21], 32'h66);

    // Conflict misses on one index from a freshly reset cache.
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    total = 0;
    do_read_miss(32'd84, 32'h66, s);   total += s;
    do_read_miss(32'd148, 32'h1025, s); total += s;
    do_read_miss(32'd84, 32'h66, s);   total += s;
    check("conflict_total_stalls", total, 32'd6);
`ifdef DMEM_CACHE_STATS_EN
    check("miss_count", dut.miss_count, 32'd3);
    check("hit_count", dut.hit_count, 32'd3);
`endif

    // Reset while FILL is in progress: the line must stay invalid.
    cpu_addr = 32'd88; cpu_rd_en = 1'b1;
    @(negedge clk);
    check("fill88_req_stall", {31'd0, stall}, 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1; cpu_rd_en = 1'b0;
    @(negedge clk);
    check("fill88_rst_stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    do_read_miss(32'd88, 32'h1016, s);

    // Store miss must not allocate; the following read misses and sees memory.
    cpu_addr = 32'd100; cpu_wr_en = 1'b1; cpu_w_data = 32'hBEEF;
    @(negedge clk);
    check("st100_mem_wr_en", {31'd0, mem_wr_en}, 32'd1);
    check("st100_stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1;
    cpu_wr_en = 1'b0;
    do_read_miss(32'd100, 32'hBEEF, s);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
